// File: rtl/hdmi_frame_pack.sv
// hdmi_frame_pack: packs the HDMI vs/de/RGB stream into 128-bit words and queues them with frame-buffer word addresses.
// Define HDMI_PACK_RGB565_EN for RGB565 (8 px/word); the default build packs RGB888 as {8'h00,R,G,B} (4 px/word).
module hdmi_frame_pack #(
    parameter int H_ACT      = 640,
    parameter int V_ACT      = 720,
    parameter int ADDR_WIDTH = 20,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  pixclk_in,
    input  logic                  rst_n,
    input  logic                  vs_in,
    input  logic                  de_in,
    input  logic [23:0]           data_in,
    output logic [127:0]          wr_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic                  frame_done,
    output logic                  overflow
);
`ifdef HDMI_PACK_RGB565_EN
    localparam int PIX_W = 16;
    localparam int PPW   = 8;
`else
    localparam int PIX_W = 32;
    localparam int PPW   = 4;
`endif
    localparam int PC_W  = $clog2(PPW);
    localparam int H_W   = $clog2(H_ACT + 1);
    localparam int V_W   = $clog2(V_ACT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    function automatic logic [PIX_W-1:0] pix_fmt(input logic [23:0] rgb);
`ifdef HDMI_PACK_RGB565_EN
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
`else
        return {8'h00, rgb};
`endif
    endfunction

    logic                  vs_q, vs2_q, de_q, de2_q, armed_q, armed_d;
    logic [H_W-1:0]        h_cnt_q, h_d;
    logic [V_W-1:0]        v_cnt_q, v_d;
    logic [PC_W-1:0]       pix_cnt_q, pix_d;
    logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
    logic [127:0]          lanes_q, lanes_d;
    logic                  word_done_q, word_done_d;
    logic                  frame_done_q, frame_done_d, overflow_q, overflow_d;
    logic                  vs_rise, de_fall, line_end, push, pop, full, do_push;

    logic [127:0]          mem_data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [127:0]          wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_valid_q;

    always_comb begin
        vs_rise  = vs_q & ~vs2_q;
        de_fall  = de2_q & ~de_q;
        line_end = armed_q & de_fall & ~vs_rise;
        // A completed word is pushed the cycle after its last pixel; a partial one at line end.
        push     = word_done_q | (line_end & (pix_cnt_q != '0));
        pop      = wr_valid_q & wr_ready;
        full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
        do_push  = push & (~full | pop);

        armed_d      = armed_q;
        h_d          = h_cnt_q;
        v_d          = v_cnt_q;
        pix_d        = pix_cnt_q;
        lanes_d      = word_done_q ? '0 : lanes_q;
        word_done_d  = 1'b0;
        frame_done_d = 1'b0;
        word_addr_d  = push ? word_addr_q + 1'b1 : word_addr_q;
        overflow_d   = overflow_q | (push & full & ~pop);

        if (vs_rise) begin
            armed_d     = 1'b1;
            h_d         = '0;
            v_d         = '0;
            pix_d       = '0;
            lanes_d     = '0;
            word_addr_d = '0;
            overflow_d  = 1'b0;
        end else begin
            if (line_end) begin
                h_d     = '0;
                pix_d   = '0;
                lanes_d = '0;
                if (v_cnt_q != V_W'(V_ACT)) v_d = v_cnt_q + 1'b1;
                frame_done_d = (v_cnt_q == V_W'(V_ACT - 1));
            end
            if (armed_q && de_in && (int'(h_d) < H_ACT) && (int'(v_d) < V_ACT)) begin
                lanes_d[int'(pix_d)*PIX_W +: PIX_W] = pix_fmt(data_in);
                word_done_d = (pix_d == PC_W'(PPW - 1));
                pix_d       = pix_d + 1'b1;
                h_d         = h_d + 1'b1;
            end
        end
    end

    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        if (do_push && !pop)      count_d = count_q + 1'b1;
        else if (!do_push && pop) count_d = count_q - 1'b1;
        // The head register bypasses the array when the new head is the word being written.
        if (count_d == '0) begin
            wr_data_d = '0;
            wr_addr_d = '0;
        end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            wr_data_d = lanes_q;
            wr_addr_d = word_addr_q;
        end else begin
            wr_data_d = mem_data_q[rd_ptr_d];
            wr_addr_d = mem_addr_q[rd_ptr_d];
        end
    end

    always_ff @(posedge pixclk_in) begin
        if (!rst_n) begin
            vs_q <= 1'b0;  vs2_q <= 1'b0;  de_q <= 1'b0;  de2_q <= 1'b0;
            armed_q      <= 1'b0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            pix_cnt_q    <= '0;
            word_addr_q  <= '0;
            word_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            wr_valid_q   <= 1'b0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
        end else begin
            vs_q <= vs_in;  vs2_q <= vs_q;  de_q <= de_in;  de2_q <= de_q;
            armed_q      <= armed_d;
            h_cnt_q      <= h_d;
            v_cnt_q      <= v_d;
            pix_cnt_q    <= pix_d;
            word_addr_q  <= word_addr_d;
            word_done_q  <= word_done_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            wr_valid_q   <= (count_d != '0);
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
        end
    end

    always_ff @(posedge pixclk_in) begin
        lanes_q <= lanes_d;
        if (do_push) begin
            mem_data_q[wr_ptr_q] <= lanes_q;
            mem_addr_q[wr_ptr_q] <= word_addr_q;
        end
    end

    assign wr_data    = wr_data_q;
    assign wr_addr    = wr_addr_q;
    assign wr_valid   = wr_valid_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_hdmi_frame_pack.sv
// Directed bench for hdmi_frame_pack with reduced geometry (32x6, 16-deep FIFO); follows HDMI_PACK_RGB565_EN.
module tb_hdmi_frame_pack;
    localparam int HA = 32;
    localparam int VA = 6;
    localparam int AW = 20;
    localparam int FD = 16;
`ifdef HDMI_PACK_RGB565_EN
    localparam int PW  = 16;
    localparam int PPW = 8;
    localparam logic [127:0] W0LIT = 128'h1126_1126_1126_1126_1106_1106_1106_1106;
`else
    localparam int PW  = 32;
    localparam int PPW = 4;
    localparam logic [127:0] W0LIT = 128'h00132333_00122232_00112131_00102030;
`endif
    localparam int WPL = HA / PPW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, vs_in = 1'b0, de_in = 1'b0, wr_ready = 1'b0;
    logic [23:0]   data_in = '0;
    logic [127:0]  wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_valid, frame_done, overflow;

    int total = 0, bad = 0;
    int cap_n = 0, fd_n = 0;
    logic [127:0]  cap_d [256];
    logic [AW-1:0] cap_a [256];

    hdmi_frame_pack #(.H_ACT(HA), .V_ACT(VA), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .pixclk_in(clk), .rst_n(rst_n), .vs_in(vs_in), .de_in(de_in), .data_in(data_in),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Handshake and frame_done are recorded mid-cycle, ahead of the edge that acts on them.
    always @(negedge clk) begin
        if (rst_n && wr_valid && wr_ready && cap_n < 256) begin
            cap_d[cap_n] = wr_data;
            cap_a[cap_n] = wr_addr;
            cap_n++;
        end
        if (frame_done) fd_n++;
    end

    function automatic logic [23:0] pix(input int i);
        logic [7:0] v;
        v = i[7:0];
        return {v + 8'h10, v + 8'h20, v + 8'h30};
    endfunction

    function automatic logic [PW-1:0] fmt(input logic [23:0] p);
`ifdef HDMI_PACK_RGB565_EN
        return {p[23:19], p[15:10], p[7:3]};
`else
        return {8'h00, p};
`endif
    endfunction

    function automatic logic [127:0] exp_word(input int base, input int n);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < PPW; k++)
            if (k < n) w[k*PW +: PW] = fmt(pix(base + k));
        return w;
    endfunction

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int n, input int base);
        for (int j = 0; j < n; j++) begin
            de_in = 1'b1;
            data_in = pix(base + j);
            tick();
        end
        de_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame_start();
        vs_in = 1'b1;
        repeat (2) tick();
        vs_in = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_words(input int target, input int bound);
        int n;
        n = 0;
        while (cap_n < target && n < bound) begin
            tick();
            n++;
        end
        chk("wait_words", 160'(cap_n >= target), 160'd1);
    endtask

    task automatic check_word(input string tag, input int idx, input int addr, input int base, input int n);
        chk({tag, "_addr"}, 160'(cap_a[idx]), 160'(addr));
        chk({tag, "_data"}, 160'(cap_d[idx]), 160'(exp_word(base, n)));
    endtask

    initial begin
        int c0, fd0, rem, b, np, n;

        // reset values
        repeat (3) tick();
        chk("rst_valid", 160'(wr_valid), 160'd0);
        chk("rst_data", 160'(wr_data), 160'd0);
        chk("rst_addr", 160'(wr_addr), 160'd0);
        chk("rst_frame_done", 160'(frame_done), 160'd0);
        chk("rst_overflow", 160'(overflow), 160'd0);
        rst_n = 1'b1;
        wr_ready = 1'b1;
        repeat (2) tick();

        // pixels before the first vs rise are ignored
        send_line(8, 900);
        repeat (5) tick();
        chk("pre_vs_words", 160'(cap_n), 160'd0);
        chk("pre_vs_valid", 160'(wr_valid), 160'd0);

        // full frame of over-long lines: 2 pixels per line ignored, one frame_done after last line
        c0 = cap_n;
        fd0 = fd_n;
        frame_start();
        for (int l = 0; l < VA - 1; l++) send_line(HA + 2, l * 64);
        chk("fd_before_last", 160'(fd_n - fd0), 160'd0);
        send_line(HA + 2, (VA - 1) * 64);
        wait_words(c0 + VA * WPL, 100);
        chk("fd_after_last", 160'(fd_n - fd0), 160'd1);
        chk("word0_literal", 160'(cap_d[c0]), 160'(W0LIT));
        for (int g = 0; g < VA * WPL; g++)
            check_word("frame", c0 + g, g, (g / WPL) * 64 + (g % WPL) * PPW, PPW);
        send_line(HA + 2, VA * 64);
        repeat (5) tick();
        chk("extra_line_words", 160'(cap_n), 160'(c0 + VA * WPL));
        chk("extra_line_fd", 160'(fd_n - fd0), 160'd1);
        chk("frame_overflow", 160'(overflow), 160'd0);

        // 13-pixel line: last word zero-filled
        c0 = cap_n;
        frame_start();
        send_line(13, 500);
        np = (13 + PPW - 1) / PPW;
        wait_words(c0 + np, 50);
        for (int w = 0; w < np; w++) begin
            n = 13 - w * PPW;
            if (n > PPW) n = PPW;
            check_word("partial", c0 + w, w, 500 + w * PPW, n);
        end

        // backpressure: 20 words offered, 16 kept, 4 dropped
        c0 = cap_n;
        wr_ready = 1'b0;
        frame_start();
        rem = 20 * PPW;
        b = 1000;
        while (rem > 0) begin
            n = (rem > HA) ? HA : rem;
            send_line(n, b);
            b += n;
            rem -= n;
        end
        chk("bp_hold_valid", 160'(wr_valid), 160'd1);
        chk("bp_hold_addr", 160'(wr_addr), 160'd0);
        chk("bp_hold_data", 160'(wr_data), 160'(exp_word(1000, PPW)));
        chk("bp_overflow", 160'(overflow), 160'd1);
        wr_ready = 1'b1;
        wait_words(c0 + 16, 100);
        for (int w = 0; w < 16; w++) check_word("bp", c0 + w, w, 1000 + w * PPW, PPW);
        repeat (4) tick();
        chk("bp_dropped", 160'(cap_n), 160'(c0 + 16));
        chk("bp_empty", 160'(wr_valid), 160'd0);
        send_line(PPW, 3000);
        wait_words(c0 + 17, 50);
        check_word("bp_next", c0 + 16, 20, 3000, PPW);
        chk("bp_overflow_sticky", 160'(overflow), 160'd1);

        // restart mid-line, vs rise coinciding with de fall
        c0 = cap_n;
        for (int j = 0; j < 3; j++) begin
            de_in = 1'b1;
            data_in = pix(3500 + j);
            tick();
        end
        de_in = 1'b0;
        vs_in = 1'b1;
        repeat (2) tick();
        vs_in = 1'b0;
        repeat (4) tick();
        chk("restart_overflow", 160'(overflow), 160'd0);
        chk("restart_no_flush", 160'(cap_n), 160'(c0));
        send_line(PPW, 4000);
        wait_words(c0 + 1, 50);
        check_word("restart", c0, 0, 4000, PPW);

        // reset during active video with 5 words queued
        c0 = cap_n;
        wr_ready = 1'b0;
        frame_start();
        for (int j = 0; j < 5 * PPW + 2; j++) begin
            de_in = 1'b1;
            data_in = pix(6000 + j);
            tick();
        end
        chk("prerst_valid", 160'(wr_valid), 160'd1);
        chk("prerst_data", 160'(wr_data), 160'(exp_word(6000, PPW)));
        rst_n = 1'b0;
        data_in = pix(6100);
        tick();
        chk("midrst_valid", 160'(wr_valid), 160'd0);
        chk("midrst_data", 160'(wr_data), 160'd0);
        chk("midrst_addr", 160'(wr_addr), 160'd0);
        chk("midrst_frame_done", 160'(frame_done), 160'd0);
        chk("midrst_overflow", 160'(overflow), 160'd0);
        rst_n = 1'b1;
        wr_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            data_in = pix(6200 + j);
            tick();
        end
        de_in = 1'b0;
        repeat (4) tick();
        send_line(HA, 7000);
        repeat (10) tick();
        chk("postrst_no_words", 160'(cap_n), 160'(c0));
        chk("postrst_valid", 160'(wr_valid), 160'd0);
        frame_start();
        send_line(PPW, 8000);
        wait_words(c0 + 1, 50);
        check_word("postrst", c0, 0, 8000, PPW);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
